playfield_board: RTL and testbench
==================================

Name: playfield_board

Overview:
- Owns the Tetris playfield, a 22-row x 12-column occupancy map, and drives `row_contents` straight into `color_mapper`.
- Accepts locked-piece writes from the piece controller, then scans for full rows.
- Collapses each full row by shifting the rows above it down, one row per cycle.
- Reports cleared-line counts to scoring and flags top-out to the game FSM.

Parameters:
- ROWS, 22, total rows including floor row (row 0 top, row ROWS-1 floor).
- COLS, 12, total columns including wall columns 0 and COLS-1.
- TOPOUT_ROWS, 2, rows 0..TOPOUT_ROWS-1 whose occupation after a lock asserts Top_out.

Ports:
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset (board cleared while 0).
- Lock_valid  in  1  lock request; four cells presented this cycle.
- Lock_ready  out  1  high only in IDLE; transfer occurs when Lock_valid && Lock_ready.
- Lock_row  in  4x5  row index of each of the 4 cells.
- Lock_col  in  4x4  column index of each of the 4 cells.
- row_contents  out  ROWSx12  occupancy, bit j = column j, 1 = filled.
- Busy  out  1  high in every state except IDLE.
- Clear_done  out  1  one-cycle pulse when scan/collapse finishes.
- Lines_cleared  out  3  rows removed by the last lock (0..4); valid in the Clear_done cycle, held until the next Clear_done.
- Top_out  out  1  sticky; cleared only by Reset.
- Lock_err  out  1  one-cycle pulse; a lock cell was illegal or already occupied.

Behaviour:
- Reset state:
  - rows 0..ROWS-2 = 12'h801 (walls only); row ROWS-1 = 12'hFFF (floor).
  - FSM = IDLE; Lock_ready = 1; all other outputs 0.
- Walls (bits 0 and 11) and the floor row are constant; no state ever clears them.
- States are IDLE, LOCK, SCAN, SHIFT, DONE.
- IDLE -> LOCK on handshake; the 4 coordinates are registered at the handshake.
- LOCK (1 cycle):
  - Each cell with row <= ROWS-2 and 1 <= col <= COLS-2 is ORed into the board.
  - Out-of-range cells are dropped.
  - An out-of-range cell, or a cell that is already 1, pulses Lock_err. The legal cells are still written.
  - Duplicate cells within one lock are not an error.
  - Top_out sets if any written cell has row < TOPOUT_ROWS.
  - Scan pointer r = ROWS-2; line count = 0. Next state SCAN.
- SCAN (1 cycle per row):
  - If row r == 12'hFFF: count += 1; shift pointer k = r; go to SHIFT.
  - Else if r == 0: go to DONE.
  - Else r -= 1.
- SHIFT (1 cycle per row):
  - If k > 0: row[k] <= row[k-1]; k -= 1.
  - If k == 0: row[0] <= 12'h801; return to SCAN with r unchanged, so the row shifted into r is rescanned.
  - A collapse at row r therefore costs r+1 cycles.
- DONE (1 cycle): Clear_done = 1; Lines_cleared = count (saturates at 7); next state IDLE.
- Latency:
  - Lock with no full rows: 1 (LOCK) + 21 (SCAN) + 1 (DONE) = 23 cycles, handshake to Clear_done.
  - Each cleared row at index r adds r+2 cycles.
- Lock_valid while Busy is ignored. The upstream block holds it until accepted.
- Reset asserted mid-SHIFT or mid-SCAN restores the reset board immediately; no partial collapse survives.
- row_contents is a register output, updated on the same edge as the board; no combinational path from Lock_* to it.

Optional Feature:
- Macro: BOARD_WIPE_EN.
- Defined:
  - Adds input port Wipe (1 bit).
  - Wipe high while in IDLE returns all rows and Top_out to reset values on the next edge, without asserting Reset.
  - Wipe outside IDLE is ignored.
  - Wipe together with a lock handshake: Wipe wins and the lock is dropped (Lock_ready deasserted that cycle).
- Undefined: no Wipe port; the board clears only via Reset.

Decomposition:
- Shared package tetris_pkg holds:
  - BOARD_ROWS = 22, BOARD_COLS = 12.
  - ROW_EMPTY = 12'h801, ROW_FULL = 12'hFFF.
  - typedef row_t (logic [11:0]); typedef cell_t (struct: row [4:0], col [3:0]).
  - typedef board_state_e for the FSM encoding.
- The same package is imported by color_mapper and the piece controller.
- One natural sub-module: board_lock_decode. It turns 4 cell_t into a ROWSx12 write mask plus the error flag. It is pure combinational and unit-tested separately.

Test Plan:
- Reset -> row_contents[0..20] = 12'h801, row_contents[21] = 12'hFFF; Lock_ready = 1; Busy = 0.
- Lock cells (20,1),(20,2),(20,3),(20,4) -> row 20 = 12'h81F; Clear_done exactly 23 cycles after the handshake; Lines_cleared = 0.
- Prefill row 20 columns 1..6; lock (20,7..10) -> row 20 full and collapsed. After collapse, row 20 = previous row 19 and row 0 = 12'h801; Lines_cleared = 1; latency 23 + 22 = 45 cycles.
- Prefill rows 17..20 each missing column 5; lock vertical I at (17..20, 5) -> Lines_cleared = 4; rows 0..20 all 12'h801; no Lock_err.
- Lock with cell (21,3) plus one already-occupied cell -> Lock_err pulses once; the floor stays 12'hFFF; the legal cells are written.
- Lock cell (1,5) -> Top_out = 1 and stays high through subsequent locks. Reset pulsed low mid-SHIFT -> reset board restored asynchronously, Top_out = 0. With BOARD_WIPE_EN defined, Wipe in IDLE -> same result on the next edge.

Source files
------------

// File: rtl/tetris_pkg.sv
// tetris_pkg: definitions shared by the playfield, the colour mapper and the
// piece controller.
//   BOARD_ROWS / BOARD_COLS / BOARD_TOPOUT_ROWS : playfield geometry
//   ROW_EMPTY / ROW_FULL                         : wall-only and fully filled rows
//   row_t, cell_t                                : one row, one (row, col) cell
//   board_state_e                                : playfield FSM encoding
//   sat_inc3                                     : 3-bit saturating increment
package tetris_pkg;

  localparam int BOARD_ROWS        = 22;
  localparam int BOARD_COLS        = 12;
  localparam int BOARD_TOPOUT_ROWS = 2;

  typedef logic [BOARD_COLS-1:0] row_t;

  localparam row_t ROW_EMPTY = 12'h801;
  localparam row_t ROW_FULL  = 12'hFFF;

  typedef struct packed {
    logic [4:0] row;
    logic [3:0] col;
  } cell_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOCK,
    ST_SCAN,
    ST_SHIFT,
    ST_DONE
  } board_state_e;

  function automatic logic [2:0] sat_inc3(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

endpackage

// File: rtl/board_lock_decode.sv
// board_lock_decode: turns the four cells of a locked piece into a
// playfield-sized write mask (purely combinational).
//   cells : the four cells of the piece
//   board : current playfield, flattened (row r at bits [r*COLS +: COLS])
//   mask  : cells to OR into the board; out-of-range cells are absent
//   err   : some cell was out of range or already occupied
//   top   : some written cell lies in the top-out zone
module board_lock_decode
  import tetris_pkg::*;
#(
  parameter int ROWS        = BOARD_ROWS,
  parameter int COLS        = BOARD_COLS,
  parameter int TOPOUT_ROWS = BOARD_TOPOUT_ROWS
) (
  input  cell_t [3:0]            cells,
  input  logic  [ROWS*COLS-1:0]  board,
  output logic  [ROWS*COLS-1:0]  mask,
  output logic                   err,
  output logic                   top
);

  localparam int IDXW = $clog2(ROWS * COLS);

  logic [3:0]      legal;
  logic [IDXW-1:0] idx [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cell
      // The floor row and both wall columns are never writable.
      assign legal[gi] = (cells[gi].row <= 5'(ROWS - 2)) &&
                         (cells[gi].col >= 4'd1) &&
                         (cells[gi].col <= 4'(COLS - 2));
      assign idx[gi]   = IDXW'(32'(cells[gi].row) * 32'(COLS) + 32'(cells[gi].col));
    end
  endgenerate

  // Occupancy is tested against the board as it was before this lock, so a
  // piece naming the same cell twice is not flagged.
  always_comb begin
    mask = '0;
    err  = 1'b0;
    top  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (legal[i]) begin
        mask[idx[i]] = 1'b1;
        if (board[idx[i]]) err = 1'b1;
        if (cells[i].row < 5'(TOPOUT_ROWS)) top = 1'b1;
      end else begin
        err = 1'b1;
      end
    end
  end

endmodule

// File: rtl/playfield_board.sv
// playfield_board: Tetris playfield occupancy map with lock, full-row scan
// and one-row-per-cycle collapse.
//   clk, rst_n              : clock, asynchronous active-low reset
//   wipe                    : (only with BOARD_WIPE_EN) clear board in IDLE
//   lock_valid / lock_ready : lock handshake, ready only in IDLE
//   lock_row / lock_col     : four cells, cell i at [5i +: 5] / [4i +: 4]
//   row_contents            : registered board, row r at [r*COLS +: COLS]
//   busy                    : high outside IDLE
//   clear_done              : one-cycle pulse at end of scan/collapse
//   lines_cleared           : rows removed by the last lock, held
//   top_out                 : sticky top-out flag
//   lock_err                : one-cycle pulse, bad or occupied lock cell
// Optional feature macro: BOARD_WIPE_EN adds the wipe input.
module playfield_board
  import tetris_pkg::*;
#(
  parameter int ROWS        = BOARD_ROWS,
  parameter int COLS        = BOARD_COLS,
  parameter int TOPOUT_ROWS = BOARD_TOPOUT_ROWS
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef BOARD_WIPE_EN
  input  logic                 wipe,
`endif
  input  logic                 lock_valid,
  output logic                 lock_ready,
  input  logic [19:0]          lock_row,
  input  logic [15:0]          lock_col,
  output logic [ROWS*COLS-1:0] row_contents,
  output logic                 busy,
  output logic                 clear_done,
  output logic [2:0]           lines_cleared,
  output logic                 top_out,
  output logic                 lock_err
);

  board_state_e state_reg, state_next;

  row_t        board_reg [ROWS];
  cell_t [3:0] cells_reg;
  cell_t [3:0] lock_cells;
  logic [4:0]  scan_reg;
  logic [4:0]  shift_reg;
  logic [2:0]  count_reg;
  logic [2:0]  lines_reg;
  logic        top_reg;
  logic        err_reg;

  logic [ROWS*COLS-1:0] board_flat;
  logic [ROWS*COLS-1:0] lock_mask;
  logic                 dec_err;
  logic                 dec_top;
  logic                 wipe_req;
  logic                 lock_fire;
  logic                 row_full;

  genvar gi;
  generate
    for (gi = 0; gi < ROWS; gi++) begin : g_flat
      assign board_flat[gi*COLS +: COLS] = board_reg[gi];
    end
    for (gi = 0; gi < 4; gi++) begin : g_cells
      assign lock_cells[gi].row = lock_row[5*gi +: 5];
      assign lock_cells[gi].col = lock_col[4*gi +: 4];
    end
  endgenerate

`ifdef BOARD_WIPE_EN
  assign wipe_req = wipe && (state_reg == ST_IDLE);
`else
  assign wipe_req = 1'b0;
`endif

  // A wipe takes priority over a lock offered in the same cycle.
  assign lock_ready = (state_reg == ST_IDLE) && !wipe_req;
  assign lock_fire  = lock_valid && lock_ready;
  assign row_full   = (board_reg[scan_reg] == ROW_FULL);

  board_lock_decode #(
    .ROWS        (ROWS),
    .COLS        (COLS),
    .TOPOUT_ROWS (TOPOUT_ROWS)
  ) u_decode (
    .cells (cells_reg),
    .board (board_flat),
    .mask  (lock_mask),
    .err   (dec_err),
    .top   (dec_top)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (lock_fire) state_next = ST_LOCK;
      ST_LOCK:  state_next = ST_SCAN;
      ST_SCAN: begin
        if (row_full)             state_next = ST_SHIFT;
        else if (scan_reg == '0)  state_next = ST_DONE;
      end
      // Returning to SCAN without moving the pointer rescans the row that
      // just dropped into place.
      ST_SHIFT: if (shift_reg == '0) state_next = ST_SCAN;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROWS; i++)
        board_reg[i] <= (i == ROWS - 1) ? ROW_FULL : ROW_EMPTY;
      cells_reg <= '0;
      scan_reg  <= '0;
      shift_reg <= '0;
      count_reg <= '0;
      lines_reg <= '0;
      top_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      err_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (wipe_req) begin
            for (int i = 0; i < ROWS; i++)
              board_reg[i] <= (i == ROWS - 1) ? ROW_FULL : ROW_EMPTY;
            top_reg <= 1'b0;
          end else if (lock_fire) begin
            cells_reg <= lock_cells;
          end
        end
        ST_LOCK: begin
          // The mask never covers walls or the floor, so they stay intact.
          for (int i = 0; i < ROWS; i++)
            board_reg[i] <= board_reg[i] | lock_mask[i*COLS +: COLS];
          err_reg   <= dec_err;
          if (dec_top) top_reg <= 1'b1;
          scan_reg  <= 5'(ROWS - 2);
          count_reg <= '0;
        end
        ST_SCAN: begin
          if (row_full) begin
            count_reg <= sat_inc3(count_reg);
            shift_reg <= scan_reg;
          end else if (scan_reg != '0) begin
            scan_reg <= scan_reg - 5'd1;
          end else begin
            lines_reg <= count_reg;
          end
        end
        ST_SHIFT: begin
          if (shift_reg != '0) begin
            board_reg[shift_reg] <= board_reg[shift_reg - 5'd1];
            shift_reg            <= shift_reg - 5'd1;
          end else begin
            board_reg[0] <= ROW_EMPTY;
          end
        end
        default: ;
      endcase
    end
  end

  assign row_contents  = board_flat;
  assign busy          = (state_reg != ST_IDLE);
  assign clear_done    = (state_reg == ST_DONE);
  assign lines_cleared = lines_reg;
  assign top_out       = top_reg;
  assign lock_err      = err_reg;

endmodule

// File: tb/tb_playfield_board.sv
// tb_playfield_board: randomized and directed locks against a queue-based
// playfield model; a monitor checks every clear_done against a scoreboard.
module tb_playfield_board;
  import tetris_pkg::*;

  localparam int ROWS = 22;
  localparam int COLS = 12;
  localparam int NB   = ROWS * COLS;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            lock_valid = 1'b0;
  logic [19:0]     lock_row = '0;
  logic [15:0]     lock_col = '0;
  logic            lock_ready, busy, clear_done, top_out, lock_err;
  logic [2:0]      lines_cleared;
  logic [NB-1:0]   row_contents;
`ifdef BOARD_WIPE_EN
  logic            wipe = 1'b0;
`endif

  always #5 clk = ~clk;

  playfield_board dut (
    .clk           (clk),
    .rst_n         (rst_n),
`ifdef BOARD_WIPE_EN
    .wipe          (wipe),
`endif
    .lock_valid    (lock_valid),
    .lock_ready    (lock_ready),
    .lock_row      (lock_row),
    .lock_col      (lock_col),
    .row_contents  (row_contents),
    .busy          (busy),
    .clear_done    (clear_done),
    .lines_cleared (lines_cleared),
    .top_out       (top_out),
    .lock_err      (lock_err)
  );

  typedef struct packed {
    logic [NB-1:0] board;
    logic [2:0]    lines;
    logic          err;
    logic          top;
    logic [31:0]   lat;
    logic [31:0]   hs;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle = 0;
  int   err_seen = 0;
  bit [11:0] mb [ROWS];
  bit        mtop;

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NB-1:0] reset_flat();
    logic [NB-1:0] f;
    for (int r = 0; r < ROWS; r++) f[r*COLS +: COLS] = (r == ROWS - 1) ? 12'hFFF : 12'h801;
    return f;
  endfunction

  function automatic logic [NB-1:0] model_flat();
    logic [NB-1:0] f;
    for (int r = 0; r < ROWS; r++) f[r*COLS +: COLS] = mb[r];
    return f;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < ROWS; r++) mb[r] = (r == ROWS - 1) ? 12'hFFF : 12'h801;
    mtop = 1'b0;
  endtask

  // Reference: write legal cells, then repeatedly delete full rows from the
  // bottom up, dropping everything above; each removal at index r costs r+2.
  function automatic exp_t model_lock(input bit [19:0] rows, input bit [15:0] cols);
    exp_t e;
    bit [11:0] q[$];
    int rr [4];
    int cc [4];
    bit ok [4];
    int lat = 23;
    int n = 0;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      rr[i] = int'(rows[5*i +: 5]);
      cc[i] = int'(cols[4*i +: 4]);
      ok[i] = (rr[i] <= ROWS - 2) && (cc[i] >= 1) && (cc[i] <= COLS - 2);
      if (!ok[i] || mb[rr[i]][cc[i]]) e.err = 1'b1;
    end
    for (int i = 0; i < 4; i++)
      if (ok[i]) begin
        mb[rr[i]][cc[i]] = 1'b1;
        if (rr[i] < 2) mtop = 1'b1;
      end
    for (int r = 0; r < ROWS - 1; r++) q.push_back(mb[r]);
    for (int r = ROWS - 2; r >= 0; r--)
      while (q[r] == 12'hFFF) begin
        lat += r + 2;
        n++;
        q.delete(r);
        q.push_front(12'h801);
      end
    for (int r = 0; r < ROWS - 1; r++) mb[r] = q[r];
    e.lines = (n > 7) ? 3'd7 : 3'(n);
    e.top   = mtop;
    e.lat   = 32'(lat);
    e.board = model_flat();
    return e;
  endfunction

  function automatic bit [19:0] pr(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic bit [15:0] pc(input int a, input int b, input int c, input int d);
    return {4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  task automatic do_lock(input bit [19:0] rows, input bit [15:0] cols);
    exp_t e;
    int n = 0;
    @(negedge clk);
    lock_row   = rows;
    lock_col   = cols;
    lock_valid = 1'b1;
    while (!lock_ready) begin
      @(negedge clk);
      n++;
      if (n > 1000) begin
        vectors++;
        miscompares++;
        $display("FAIL lock_accept: lock_ready stayed %0b, required 1 within 1000 cycles", lock_ready);
        lock_valid = 1'b0;
        return;
      end
    end
    e = model_lock(rows, cols);
    e.hs = 32'(cycle);
    sb.push_back(e);
    $display("lock rows=%h cols=%h exp_lines=%0d exp_err=%0b exp_lat=%0d", rows, cols, e.lines, e.err, e.lat);
    @(negedge clk);
    lock_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 || !lock_ready) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        vectors++;
        miscompares++;
        $display("FAIL wait_idle: %0d locks still pending, required 0", sb.size());
        sb.delete();
        break;
      end
    end
  endtask

  // Monitor: compare every completed lock against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (lock_err) err_seen++;
      if (clear_done) begin
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_clear_done: got clear_done=1, required no pending lock");
        end else begin
          mon_e = sb.pop_front();
          check("lines_cleared", NB'(lines_cleared), NB'(mon_e.lines));
          check("lock_err_pulses", NB'(err_seen), NB'(mon_e.err));
          check("top_out", NB'(top_out), NB'(mon_e.top));
          check("latency", NB'(cycle - int'(mon_e.hs)), NB'(mon_e.lat));
          check("board", row_contents, mon_e.board);
          check("busy_ready_in_done", NB'({busy, lock_ready}), NB'(2'b10));
        end
        err_seen = 0;
      end
    end
  end

  initial begin
    bit [19:0] rr;
    bit [15:0] cc;
    int miss[$];

    // Reset state
    model_reset();
    #12;
    check("reset_board", row_contents, reset_flat());
    check("reset_ready", NB'(lock_ready), NB'(1));
    check("reset_busy", NB'(busy), NB'(0));
    check("reset_misc", NB'({clear_done, lines_cleared, top_out, lock_err}), NB'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Simple lock, then fill and clear row 20 (duplicate cells are not errors)
    do_lock(pr(20, 20, 20, 20), pc(1, 2, 3, 4));
    wait_idle();
    check("row20_81f", NB'(row_contents[20*COLS +: COLS]), NB'(12'h81F));
    do_lock(pr(20, 20, 20, 20), pc(5, 6, 5, 6));
    do_lock(pr(20, 20, 20, 20), pc(7, 8, 9, 10));
    wait_idle();
    check("row0_after_clear", NB'(row_contents[0 +: COLS]), NB'(12'h801));
    check("lines_one", NB'(lines_cleared), NB'(1));

    // Four rows missing column 5, then a vertical I
    for (int r = 17; r <= 20; r++) begin
      do_lock(pr(r, r, r, r), pc(1, 2, 3, 4));
      do_lock(pr(r, r, r, r), pc(6, 7, 8, 9));
    end
    do_lock(pr(17, 18, 19, 20), pc(10, 10, 10, 10));
    do_lock(pr(17, 18, 19, 20), pc(5, 5, 5, 5));
    wait_idle();
    check("lines_four", NB'(lines_cleared), NB'(4));
    check("board_empty_after_tetris", row_contents, reset_flat());

    // Floor cell plus an occupied cell
    do_lock(pr(20, 20, 20, 20), pc(1, 1, 1, 1));
    do_lock(pr(21, 20, 20, 19), pc(3, 1, 2, 4));
    wait_idle();
    check("floor_intact", NB'(row_contents[21*COLS +: COLS]), NB'(12'hFFF));
    check("row20_legal_written", NB'(row_contents[20*COLS +: COLS]), NB'(12'h807));
    check("row19_legal_written", NB'(row_contents[19*COLS +: COLS]), NB'(12'h811));

    // Top-out, then random traffic issued back to back
    do_lock(pr(1, 1, 1, 1), pc(5, 5, 5, 5));
    wait_idle();
    check("top_out_set", NB'(top_out), NB'(1));
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) begin
          rr[5*i +: 5] = 5'($urandom_range(17, 21));
          cc[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(11, 15));
        end else begin
          rr[5*i +: 5] = 5'($urandom_range(17, 20));
          cc[4*i +: 4] = 4'($urandom_range(1, 10));
        end
      end
      do_lock(rr, cc);
    end
    wait_idle();
    check("top_out_sticky", NB'(top_out), NB'(1));

    // Complete row 20 and reset in the middle of its collapse
    for (int c = 1; c <= 10; c++) if (!mb[20][c]) miss.push_back(c);
    while (miss.size() > 1) begin
      do_lock(pr(20, 20, 20, 20), pc(miss[0], miss[0], miss[0], miss[0]));
      void'(miss.pop_front());
    end
    wait_idle();
    do_lock(pr(20, 20, 20, 20), pc(miss[0], miss[0], miss[0], miss[0]));
    repeat (4) @(negedge clk);
    check("busy_mid_shift", NB'(busy), NB'(1));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_board", row_contents, reset_flat());
    check("async_reset_flags", NB'({busy, lock_ready, top_out, lines_cleared}), NB'(6'b010000));
    sb.delete();
    err_seen = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    do_lock(pr(20, 19, 20, 19), pc(2, 2, 3, 3));
    wait_idle();

`ifdef BOARD_WIPE_EN
    do_lock(pr(1, 1, 1, 1), pc(5, 5, 5, 5));
    wait_idle();
    @(negedge clk);
    wipe       = 1'b1;
    lock_valid = 1'b1;
    lock_row   = pr(20, 20, 20, 20);
    lock_col   = pc(1, 2, 3, 4);
    #1;
    check("wipe_blocks_ready", NB'(lock_ready), NB'(0));
    @(negedge clk);
    check("wipe_board", row_contents, reset_flat());
    check("wipe_flags", NB'({busy, top_out}), NB'(2'b00));
    wipe       = 1'b0;
    lock_valid = 1'b0;
    model_reset();
    repeat (30) @(negedge clk);
`endif

    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
